// File: rtl/data_tx_framer.sv
// Byte framer between accumulator storage and the UART transmitter: pulls storage bytes,
// merges generated EOD bytes through a small FIFO. Optional trailing checksum: FRAMER_CHECKSUM_EN.
module data_tx_framer #(
  parameter int GEN_DEPTH     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        ReadClock,
  input  logic        nReset,
  input  logic        Enable,
  input  logic [7:0]  DataIn,
  input  logic        DataReady,
  input  logic [7:0]  GenData,
  input  logic        GenStrobe,
  input  logic        TxBusy,
  output logic        ReadEnable,
  output logic [7:0]  TxData,
  output logic        TxStart,
  output logic [10:0] ByteCount,
  output logic        GenOverflow,
  output logic        Busy
);

  localparam int AW = (GEN_DEPTH > 1) ? $clog2(GEN_DEPTH) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [AW:0]   GEN_FULL    = (AW+1)'(GEN_DEPTH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_GEN    = 3'd3;
`ifdef FRAMER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd4;
`endif
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [7:0]    r_gen_mem [GEN_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_gen_cnt;
  logic [2:0]    r_state;
  logic [SW-1:0] r_settle_cnt;
  logic          r_last_80, r_pair_done;
  logic          r_read_enable, r_tx_start, r_gen_overflow, r_busy;
  logic [7:0]    r_tx_data;
  logic [10:0]   r_byte_count;
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0]    r_csum;
  logic          r_csum_armed;
`endif

  logic          w_gen_empty, w_gen_full, w_decide, w_go_gen, w_go_data;
  logic          w_push, w_pop, w_csum_fire, w_rec_clear;
  logic [7:0]    w_head;
  logic [2:0]    w_next_state;
  logic [AW:0]   w_next_cnt;

  assign w_gen_empty = (r_gen_cnt == (AW+1)'(0));
  assign w_gen_full  = (r_gen_cnt == GEN_FULL);
  assign w_head      = r_gen_mem[r_rd_ptr];
  // The last SETTLE cycle makes the same launch decision as IDLE, so data bytes run 1+SETTLE_CYCLES apart.
  assign w_decide    = (r_state == S_IDLE) ||
                       ((r_state == S_SETTLE) && (r_settle_cnt == SETTLE_LAST));
  assign w_go_gen    = w_decide && !w_gen_empty && !TxBusy;
  assign w_go_data   = w_decide && !w_go_gen && DataReady && Enable && !TxBusy;
  assign w_pop       = w_go_gen;
  assign w_push      = GenStrobe && (!w_gen_full || w_pop);

`ifdef FRAMER_CHECKSUM_EN
  assign w_csum_fire = (r_state == S_CSUM) && r_csum_armed && !TxBusy;
  assign w_rec_clear = w_csum_fire;
`else
  assign w_csum_fire = 1'b0;
  assign w_rec_clear = (r_state == S_GEN) && r_pair_done;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_SETTLE: begin
        if (w_go_gen)                                           w_next_state = S_GEN;
        else if (w_go_data)                                     w_next_state = S_DATA;
        else if ((r_state == S_SETTLE) && !w_decide)            w_next_state = S_SETTLE;
        else                                                    w_next_state = S_IDLE;
      end
      S_DATA: w_next_state = S_SETTLE;
      S_GEN: begin
`ifdef FRAMER_CHECKSUM_EN
        if (r_pair_done) w_next_state = S_CSUM;
        else             w_next_state = S_GAP;
`else
        w_next_state = S_GAP;
`endif
      end
`ifdef FRAMER_CHECKSUM_EN
      S_CSUM: begin
        if (w_csum_fire) w_next_state = S_GAP;
        else             w_next_state = S_CSUM;
      end
`endif
      // GAP spans the cycle after any TxStart, when the UART busy flag is not yet meaningful.
      S_GAP: begin
        if (r_tx_start) w_next_state = S_GAP;
        else            w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_cnt = r_gen_cnt;
    case ({w_push, w_pop})
      2'b10:   w_next_cnt = r_gen_cnt + (AW+1)'(1);
      2'b01:   w_next_cnt = r_gen_cnt - (AW+1)'(1);
      default: w_next_cnt = r_gen_cnt;
    endcase
  end

  always_ff @(posedge ReadClock) begin
    if (w_push) r_gen_mem[r_wr_ptr] <= GenData;
  end

  always_ff @(posedge ReadClock) begin
    if (!nReset) begin
      r_state        <= S_IDLE;
      r_settle_cnt   <= SW'(0);
      r_wr_ptr       <= AW'(0);
      r_rd_ptr       <= AW'(0);
      r_gen_cnt      <= (AW+1)'(0);
      r_last_80      <= 1'b0;
      r_pair_done    <= 1'b0;
      r_read_enable  <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_byte_count   <= 11'd0;
      r_gen_overflow <= 1'b0;
      r_busy         <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
      r_csum         <= 8'h00;
      r_csum_armed   <= 1'b0;
`endif
    end else begin
      r_state       <= w_next_state;
      r_settle_cnt  <= ((r_state == S_SETTLE) && (w_next_state == S_SETTLE)) ?
                       r_settle_cnt + SW'(1) : SW'(0);
      r_read_enable <= w_go_data;
      r_tx_start    <= w_go_gen | w_go_data | w_csum_fire;
      r_gen_cnt     <= w_next_cnt;
      r_busy        <= (w_next_state != S_IDLE) || (w_next_cnt != (AW+1)'(0));
      if (w_push)                r_wr_ptr       <= r_wr_ptr + AW'(1);
      if (w_pop)                 r_rd_ptr       <= r_rd_ptr + AW'(1);
      if (GenStrobe && !w_push)  r_gen_overflow <= 1'b1;
      // EOD pair detection: 0x01 counts only when the previously popped gen byte was 0x80.
      if (w_pop) begin
        r_last_80   <= (w_head == 8'h80);
        r_pair_done <= r_last_80 && (w_head == 8'h01);
      end else begin
        r_pair_done <= 1'b0;
      end
      if (w_go_gen)       r_tx_data <= w_head;
      else if (w_go_data) r_tx_data <= DataIn;
`ifdef FRAMER_CHECKSUM_EN
      else if (w_csum_fire) r_tx_data <= r_csum;
      r_csum_armed <= (r_state == S_CSUM) && !w_csum_fire;
      if (w_csum_fire)    r_csum <= 8'h00;
      else if (w_go_data) r_csum <= r_csum + DataIn;
`endif
      if (w_rec_clear)                             r_byte_count <= 11'd0;
      else if (w_go_data && (r_byte_count != 11'd2047)) r_byte_count <= r_byte_count + 11'd1;
    end
  end

  assign ReadEnable  = r_read_enable;
  assign TxData      = r_tx_data;
  assign TxStart     = r_tx_start;
  assign ByteCount   = r_byte_count;
  assign GenOverflow = r_gen_overflow;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_data_tx_framer.sv
// Directed bench for data_tx_framer; expectations follow FRAMER_CHECKSUM_EN when defined.
module tb_data_tx_framer;
  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Enable = 1'b1;
  logic [7:0]  DataIn = 8'h00;
  logic        DataReady = 1'b0;
  logic [7:0]  GenData = 8'h00;
  logic        GenStrobe = 1'b0;
  logic        TxBusy = 1'b0;
  logic        ReadEnable, TxStart, GenOverflow, Busy;
  logic [7:0]  TxData;
  logic [10:0] ByteCount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int re_cnt = 0;
  int re_alone = 0;
  int last_data_cyc = -1000;
  int min_gap = 1000;
  bit hold_bad = 1'b0;
  bit resume_ok = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] data_arr[1024];

  data_tx_framer dut (
    .ReadClock(clk), .nReset(nReset), .Enable(Enable), .DataIn(DataIn),
    .DataReady(DataReady), .GenData(GenData), .GenStrobe(GenStrobe), .TxBusy(TxBusy),
    .ReadEnable(ReadEnable), .TxData(TxData), .TxStart(TxStart), .ByteCount(ByteCount),
    .GenOverflow(GenOverflow), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and log what the DUT transmitted.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (TxStart) tx_q.push_back(TxData);
    if (ReadEnable) re_cnt++;
    if (ReadEnable && !TxStart) re_alone++;
    if (ReadEnable && TxStart) begin
      if (cyc - last_data_cyc < min_gap) min_gap = cyc - last_data_cyc;
      last_data_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0; DataReady = 1'b0; GenStrobe = 1'b0; TxBusy = 1'b0; Enable = 1'b1;
    tick(); tick();
    nReset = 1'b1;
    tx_q.delete();
  endtask

  // Storage model: serves data_arr bytes, advancing on each ReadEnable; optional 10-cycle TxBusy hold.
  task automatic run_record(input int n, input int busy_after, output bit timed_out);
    int idx = 0;
    int hold = 0;
    bit held = 1'b0;
    bit expect_res = 1'b0;
    hold_bad = 1'b0; resume_ok = 1'b0;
    last_data_cyc = -1000; min_gap = 1000;
    DataIn = data_arr[0]; DataReady = (n > 0);
    for (int c = 0; c < n * 6 + 200; c++) begin
      tick();
      if (expect_res) begin resume_ok = TxStart && ReadEnable; expect_res = 1'b0; end
      if (hold > 0) begin
        if (TxStart || ReadEnable) hold_bad = 1'b1;
        hold--;
        if (hold == 0) begin TxBusy = 1'b0; expect_res = 1'b1; end
      end
      if (ReadEnable) begin
        idx++;
        DataIn = (idx < n) ? data_arr[idx] : 8'h00;
        DataReady = (idx < n);
      end
      if (busy_after > 0 && !held && idx == busy_after) begin
        TxBusy = 1'b1; hold = 10; held = 1'b1;
      end
      if (idx == n && hold == 0 && !expect_res) break;
    end
    timed_out = (idx < n);
    DataReady = 1'b0;
  endtask

  task automatic send_eod();
    GenData = 8'h80; GenStrobe = 1'b1; tick();
    GenData = 8'h01; tick();
    GenStrobe = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ReadEnable !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", ReadEnable); end
    checks++; if (TxStart !== 1'b0) begin errors++; $display("FAIL reset_txstart got %b exp 0", TxStart); end
    checks++; if (TxData !== 8'h00) begin errors++; $display("FAIL reset_txdata got %h exp 00", TxData); end
    checks++; if (ByteCount !== 11'd0) begin errors++; $display("FAIL reset_bytecount got %0d exp 0", ByteCount); end
    checks++; if (GenOverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", GenOverflow); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
  endtask

  task automatic test_full_record();
    bit to;
    int re0;
    do_reset();
    for (int i = 0; i < 1024; i++) data_arr[i] = 8'(i);
    re0 = re_cnt;
    run_record(1024, 0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout got %b exp 0", to); end
    checks++; if (re_cnt - re0 != 1024) begin errors++; $display("FAIL full_re_count got %0d exp 1024", re_cnt - re0); end
    checks++; if (re_alone != 0) begin errors++; $display("FAIL full_re_without_txstart got %0d exp 0", re_alone); end
    checks++; if (min_gap < 3) begin errors++; $display("FAIL full_spacing got %0d exp >=3", min_gap); end
    checks++; if (tx_q.size() != 1024) begin errors++; $display("FAIL full_tx_count got %0d exp 1024", tx_q.size()); end
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== 8'(i)) begin
        errors++; $display("FAIL full_byte[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, 8'(i));
      end
    end
    checks++; if (ByteCount !== 11'd1024) begin errors++; $display("FAIL full_bytecount got %0d exp 1024", ByteCount); end
    tx_q.delete(); re0 = re_cnt;
    send_eod();
    exp_q = '{8'h80, 8'h01};
`ifdef FRAMER_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL full_eod_len got %0d exp %0d", tx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_eod[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (re_cnt != re0) begin errors++; $display("FAIL full_eod_re got %0d exp 0", re_cnt - re0); end
    checks++; if (ByteCount !== 11'd0) begin errors++; $display("FAIL full_eod_bytecount got %0d exp 0", ByteCount); end
  endtask

  task automatic test_busy_hold();
    bit to;
    do_reset();
    for (int i = 0; i < 8; i++) data_arr[i] = 8'hA0 + 8'(i);
    run_record(8, 3, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_timeout got %b exp 0", to); end
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL busy_activity_in_hold got %b exp 0", hold_bad); end
    checks++; if (resume_ok !== 1'b1) begin errors++; $display("FAIL busy_resume_1cycle got %b exp 1", resume_ok); end
    checks++; if (tx_q.size() != 8) begin errors++; $display("FAIL busy_tx_count got %0d exp 8", tx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL busy_byte[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, 8'hA0 + 8'(i));
      end
    end
    checks++; if (ByteCount !== 11'd8) begin errors++; $display("FAIL busy_bytecount got %0d exp 8", ByteCount); end
  endtask

  task automatic test_gen_while_disabled();
    int re0;
    do_reset();
    Enable = 1'b0; DataReady = 1'b1; DataIn = 8'h55;
    re0 = re_cnt;
    send_eod();
    exp_q = '{8'h80, 8'h01};
`ifdef FRAMER_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL dis_len got %0d exp %0d", tx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL dis_byte[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (re_cnt != re0) begin errors++; $display("FAIL dis_readenable got %0d exp 0", re_cnt - re0); end
    DataReady = 1'b0; Enable = 1'b1;
  endtask

  task automatic test_gen_overflow();
    do_reset();
    TxBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      GenData = 8'h11 + 8'(i); GenStrobe = 1'b1; tick();
    end
    GenStrobe = 1'b0; tick(); tick();
    checks++; if (GenOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", GenOverflow); end
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL ovf_sent_while_busy got %0d exp 0", tx_q.size()); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", Busy); end
    TxBusy = 1'b0;
    repeat (30) tick();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    checks++; if (tx_q.size() != 4) begin errors++; $display("FAIL ovf_kept got %0d exp 4", tx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_byte[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (GenOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", GenOverflow); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ovf_drained_busy got %b exp 0", Busy); end
    do_reset();
    checks++; if (GenOverflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", GenOverflow); end
  endtask

  task automatic test_checksum_record();
    bit to;
    do_reset();
    data_arr[0] = 8'h10; data_arr[1] = 8'h20; data_arr[2] = 8'hF5;
    run_record(3, 0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL csum_timeout got %b exp 0", to); end
    checks++; if (ByteCount !== 11'd3) begin errors++; $display("FAIL csum_bytecount_pre got %0d exp 3", ByteCount); end
    send_eod();
    exp_q = '{8'h10, 8'h20, 8'hF5, 8'h80, 8'h01};
`ifdef FRAMER_CHECKSUM_EN
    exp_q.push_back(8'h25);
`endif
    checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL csum_len got %0d exp %0d", tx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL csum_byte[%0d] got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (ByteCount !== 11'd0) begin errors++; $display("FAIL csum_bytecount_post got %0d exp 0", ByteCount); end
  endtask

  task automatic test_reset_mid_transfer();
    bit seen = 1'b0;
    bit to;
    do_reset();
    DataIn = 8'h33; DataReady = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (ReadEnable) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_data_started got %b exp 1", seen); end
    GenData = 8'h77; GenStrobe = 1'b1; tick();
    GenStrobe = 1'b0; nReset = 1'b0; DataReady = 1'b0;
    tick();
    checks++; if (ReadEnable !== 1'b0) begin errors++; $display("FAIL midrst_re got %b exp 0", ReadEnable); end
    checks++; if (TxStart !== 1'b0) begin errors++; $display("FAIL midrst_txstart got %b exp 0", TxStart); end
    checks++; if (TxData !== 8'h00) begin errors++; $display("FAIL midrst_txdata got %h exp 00", TxData); end
    checks++; if (ByteCount !== 11'd0) begin errors++; $display("FAIL midrst_bytecount got %0d exp 0", ByteCount); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", Busy); end
    nReset = 1'b1; tx_q.delete();
    repeat (10) tick();
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL midrst_fifo_flushed got %0d bytes exp 0", tx_q.size()); end
    data_arr[0] = 8'h44; data_arr[1] = 8'h45;
    run_record(2, 0, to);
    checks++; if (ByteCount !== 11'd2) begin errors++; $display("FAIL midrst_fresh_count got %0d exp 2", ByteCount); end
    checks++; if (tx_q.size() != 2 || tx_q[0] !== 8'h44 || tx_q[1] !== 8'h45) begin
      errors++; $display("FAIL midrst_fresh_bytes got %0d bytes exp 44 45", tx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_record();
    test_busy_hold();
    test_gen_while_disabled();
    test_gen_overflow();
    test_checksum_record();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
